// File: rtl/traffic_light_pkg.sv
// Shared types and default timing for the two-road traffic light controller.
package traffic_light_pkg;

  // Controller phases; 3-bit encoding, seven states in service order.
  typedef enum logic [2:0] {
    AR_INIT  = 3'd0,
    NS_G     = 3'd1,
    NS_Y     = 3'd2,
    AR_NS2EW = 3'd3,
    EW_G     = 3'd4,
    EW_Y     = 3'd5,
    AR_EW2NS = 3'd6
  } tlc_state_e;

  // Default phase durations in clock cycles.
  localparam int DEF_NS_MIN_GREEN = 50;
  localparam int DEF_EW_GREEN     = 30;
  localparam int DEF_YELLOW       = 5;
  localparam int DEF_ALL_RED      = 2;
  localparam int DEF_TIMER_W      = 8;

  // One direction's signal head.
  typedef struct packed {
    logic red;
    logic yellow;
    logic green;
  } lamp_t;

  localparam lamp_t LAMP_RED    = '{red: 1'b1, yellow: 1'b0, green: 1'b0};
  localparam lamp_t LAMP_YELLOW = '{red: 1'b0, yellow: 1'b1, green: 1'b0};
  localparam lamp_t LAMP_GREEN  = '{red: 1'b0, yellow: 1'b0, green: 1'b1};

endpackage

// File: rtl/tlc_phase_timer.sv
// Per-phase cycle counter: synchronous clear, counts up, saturates at all-ones
// so an indefinitely held phase never wraps back under its minimum.
module tlc_phase_timer #(
  parameter int TIMER_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clear,
  output logic [TIMER_W-1:0] o_count
);

  localparam logic [TIMER_W-1:0] COUNT_MAX = {TIMER_W{1'b1}};

  logic [TIMER_W-1:0] r_count;

  // Count cycles within the current phase; reset and clear both return to 0.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order between blocks.
    if (!rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (r_count != COUNT_MAX) begin
      r_count <= r_count + TIMER_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/traffic_light_controller.sv
// Two-road intersection controller. NS is the default-green main road; EW is
// served on demand from a synchronous vehicle sensor. Moore FSM: lamps decode
// only the state register, so the sensor never reaches an output directly.
module traffic_light_controller
  import traffic_light_pkg::*;
#(
  parameter int NS_MIN_GREEN = DEF_NS_MIN_GREEN,
  parameter int EW_GREEN     = DEF_EW_GREEN,
  parameter int YELLOW       = DEF_YELLOW,
  parameter int ALL_RED      = DEF_ALL_RED,
  parameter int TIMER_W      = DEF_TIMER_W
) (
  input  logic clk,
  input  logic rst,
  input  logic sensor,
  output logic NS_Red,
  output logic NS_Yellow,
  output logic NS_Green,
  output logic EW_Red,
  output logic EW_Yellow,
  output logic EW_Green
);

  // A phase of duration D ends on the edge where the timer reads D-1.
  localparam logic [TIMER_W-1:0] NS_MIN_LAST  = TIMER_W'(NS_MIN_GREEN - 1);
  localparam logic [TIMER_W-1:0] EW_GREEN_LAST = TIMER_W'(EW_GREEN - 1);
  localparam logic [TIMER_W-1:0] YELLOW_LAST  = TIMER_W'(YELLOW - 1);
  localparam logic [TIMER_W-1:0] ALL_RED_LAST = TIMER_W'(ALL_RED - 1);

  tlc_state_e         r_state;
  tlc_state_e         w_next_state;
  logic               r_req_q;
  logic               w_pending;
  logic               w_state_change;
  logic               w_enter_ew_g;
  logic [TIMER_W-1:0] w_timer;
  lamp_t              w_ns_lamp;
  lamp_t              w_ew_lamp;

  assign w_pending      = r_req_q | sensor;
  assign w_state_change = (w_next_state != r_state);
  assign w_enter_ew_g   = (w_next_state == EW_G) && (r_state != EW_G);

  tlc_phase_timer #(
    .TIMER_W (TIMER_W)
  ) u_phase_timer (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_state_change),
    .o_count (w_timer)
  );

  // State register; reset always lands in the all-red start-up phase.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= AR_INIT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // EW demand latch: the sensor is ignored while EW is already green, and
  // entering EW green consumes the request even if the sensor is still high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_req_q <= 1'b0;
    end else if (w_enter_ew_g) begin
      r_req_q <= 1'b0;
    end else if (sensor && (r_state != EW_G)) begin
      r_req_q <= 1'b1;
    end
  end

  // Next-state logic: timed phases advance in a fixed ring; NS green waits
  // for both its minimum time and EW demand.
  always_comb begin
    // NOTE: default assigned first so no path through the case leaves the
    // signal unassigned, which would otherwise infer a latch.
    w_next_state = r_state;
    case (r_state)
      AR_INIT:  if (w_timer == ALL_RED_LAST) w_next_state = NS_G;
      NS_G:     if ((w_timer >= NS_MIN_LAST) && w_pending) w_next_state = NS_Y;
      NS_Y:     if (w_timer == YELLOW_LAST) w_next_state = AR_NS2EW;
      AR_NS2EW: if (w_timer == ALL_RED_LAST) w_next_state = EW_G;
      EW_G:     if (w_timer == EW_GREEN_LAST) w_next_state = EW_Y;
      EW_Y:     if (w_timer == YELLOW_LAST) w_next_state = AR_EW2NS;
      AR_EW2NS: if (w_timer == ALL_RED_LAST) w_next_state = NS_G;
      default:  w_next_state = AR_INIT;
    endcase
  end

  // Lamp decode from the state register only; red unless the phase says otherwise.
  always_comb begin
    w_ns_lamp = LAMP_RED;
    w_ew_lamp = LAMP_RED;
    case (r_state)
      NS_G:    w_ns_lamp = LAMP_GREEN;
      NS_Y:    w_ns_lamp = LAMP_YELLOW;
      EW_G:    w_ew_lamp = LAMP_GREEN;
      EW_Y:    w_ew_lamp = LAMP_YELLOW;
      default: ;
    endcase
  end

  assign NS_Red    = w_ns_lamp.red;
  assign NS_Yellow = w_ns_lamp.yellow;
  assign NS_Green  = w_ns_lamp.green;
  assign EW_Red    = w_ew_lamp.red;
  assign EW_Yellow = w_ew_lamp.yellow;
  assign EW_Green  = w_ew_lamp.green;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Bench for traffic_light_controller. The stimulus process queues the phase
// sequence it expects (lamp pattern + length in cycles); a monitor measures
// each completed phase on the lamp outputs and compares it against the queue.
module tb_traffic_light_controller;

  localparam int NS_MIN = 50;
  localparam int EW_GRN = 30;
  localparam int YEL    = 5;
  localparam int AR     = 2;

  // Lamp vector order: {NS_Red, NS_Yellow, NS_Green, EW_Red, EW_Yellow, EW_Green}
  localparam logic [5:0] L_AR  = 6'b100_100;
  localparam logic [5:0] L_NSG = 6'b001_100;
  localparam logic [5:0] L_NSY = 6'b010_100;
  localparam logic [5:0] L_EWG = 6'b100_001;
  localparam logic [5:0] L_EWY = 6'b100_010;

  typedef struct {
    string      name;
    logic [5:0] lamps;
    int         len;
  } phase_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sensor = 1'b0;
  logic NS_Red, NS_Yellow, NS_Green, EW_Red, EW_Yellow, EW_Green;
  logic [5:0] lamps;

  phase_t exp_q[$];
  int     n_tests = 0;
  int     n_fail = 0;
  int     inv_errors = 0;
  int     ew_runs = 0;
  bit     free_mode = 1'b0;

  assign lamps = {NS_Red, NS_Yellow, NS_Green, EW_Red, EW_Yellow, EW_Green};

  always #5 clk = ~clk;

  traffic_light_controller dut (
    .clk       (clk),
    .rst       (rst),
    .sensor    (sensor),
    .NS_Red    (NS_Red),
    .NS_Yellow (NS_Yellow),
    .NS_Green  (NS_Green),
    .EW_Red    (EW_Red),
    .EW_Yellow (EW_Yellow),
    .EW_Green  (EW_Green)
  );

  task automatic check(input string name, input int actual, input int expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic push(input string name, input logic [5:0] l, input int len);
    phase_t p;
    p.name  = name;
    p.lamps = l;
    p.len   = len;
    exp_q.push_back(p);
  endtask

  // Advance n rising edges, then step 1 time unit past the last one.
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    cycles(n);
    rst = 1'b1;
  endtask

  // Judge a completed phase: against the queue if one is expected, else by
  // the timing rules when free-running, else it is an unexpected transition.
  task automatic end_run(input logic [5:0] l, input int len);
    phase_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({e.name, "_lamps"}, l, e.lamps);
      check({e.name, "_len"}, len, e.len);
    end else if (free_mode) begin
      case (l)
        L_NSG: check("free_ns_green_min", int'(len >= NS_MIN), 1);
        L_NSY: check("free_ns_yellow_len", len, YEL);
        L_AR:  check("free_all_red_len", len, AR);
        L_EWG: begin
          ew_runs++;
          check("free_ew_green_len", len, EW_GRN);
        end
        L_EWY: check("free_ew_yellow_len", len, YEL);
        default: check("free_phase_lamps", l, L_AR);
      endcase
    end else begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_phase: got lamps 0x%0h for %0d cycles, expected no change",
               l, len);
    end
  endtask

  // Monitor: sample lamps mid-cycle, check per-cycle invariants, and hand
  // each finished phase to the scoreboard.
  initial begin
    logic [5:0] cur;
    logic [5:0] smp;
    int         run_len;
    @(posedge clk);
    @(negedge clk);
    cur     = lamps;
    run_len = 1;
    forever begin
      @(negedge clk);
      smp = lamps;
      if ((smp[2] & smp[0]) || ($countones(smp[5:3]) != 1) || ($countones(smp[2:0]) != 1))
        inv_errors++;
      if (smp == cur) begin
        run_len++;
      end else begin
        end_run(cur, run_len);
        cur     = smp;
        run_len = 1;
      end
    end
  end

  // Stimulus. Edge numbers in comments count rising edges from time 0.
  initial begin
    // S1: 10-cycle reset, short pulse early in NS green, one full EW service.
    push("s1_reset_all_red", L_AR, 11);
    push("s1_ns_green", L_NSG, NS_MIN);
    push("s1_ns_yellow", L_NSY, YEL);
    push("s1_ar_ns2ew", L_AR, AR);
    push("s1_ew_green", L_EWG, EW_GRN);
    push("s1_ew_yellow", L_EWY, YEL);
    push("s1_ar_ew2ns", L_AR, AR);
    do_reset(10);                 // edge 10; NS green from edge 12
    cycles(6);                    // edge 16
    sensor = 1'b1;
    cycles(1);                    // edge 17 captures one-cycle pulse
    sensor = 0;

    // S2: demand after a long idle NS green, then sensor high only during EW green.
    push("s2_ns_green_idle", L_NSG, 300);
    push("s2_ns_yellow", L_NSY, YEL);
    push("s2_ar_ns2ew", L_AR, AR);
    push("s2_ew_green", L_EWG, EW_GRN);
    push("s2_ew_yellow", L_EWY, YEL);
    push("s2_ar_ew2ns", L_AR, AR);
    cycles(388);                  // edge 405
    sensor = 1'b1;
    cycles(1);                    // edge 406: NS yellow starts
    sensor = 1'b0;
    cycles(7);                    // edge 413: EW green entered
    sensor = 1'b1;
    cycles(30);                   // edges 414..443 all in EW green
    sensor = 1'b0;

    // S3: 4000 idle cycles (no stray EW phase), then reset in mid EW green.
    push("s3_ns_green_4000", L_NSG, 4000);
    push("s3_ns_yellow", L_NSY, YEL);
    push("s3_ar_ns2ew", L_AR, AR);
    push("s3_ew_green_cut", L_EWG, 11);
    push("s3_reset_all_red", L_AR, 4);
    cycles(4006);                 // edge 4449
    sensor = 1'b1;
    cycles(1);                    // edge 4450
    sensor = 1'b0;
    cycles(17);                   // edge 4467; EW green since edge 4457
    do_reset(3);                  // edges 4468..4470 in reset; NS green at 4472

    // S4: sensor exactly at minimum expiry, then demand latched during EW yellow.
    push("s4_ns_green_min", L_NSG, NS_MIN);
    push("s4_ns_yellow", L_NSY, YEL);
    push("s4_ar_ns2ew", L_AR, AR);
    push("s4_ew_green", L_EWG, EW_GRN);
    push("s4_ew_yellow", L_EWY, YEL);
    push("s4_ar_ew2ns", L_AR, AR);
    push("s4_ns_green_latched", L_NSG, NS_MIN);
    push("s4b_ns_yellow", L_NSY, YEL);
    push("s4b_ar_ns2ew", L_AR, AR);
    push("s4b_ew_green", L_EWG, EW_GRN);
    push("s4b_ew_yellow", L_EWY, YEL);
    push("s4b_ar_ew2ns", L_AR, AR);
    cycles(51);                   // edge 4521
    sensor = 1'b1;
    cycles(1);                    // edge 4522: timer 49, NS yellow starts
    sensor = 1'b0;
    cycles(38);                   // edge 4560
    sensor = 1'b1;
    cycles(1);                    // edge 4561: EW yellow, request latched
    sensor = 1'b0;
    cycles(99);                   // edge 4660: NS green just entered

    // S5: self-toggling sensor; phases judged by the timing rules.
    free_mode = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      sensor = sensor ^ NS_Green ^ EW_Green ^ NS_Yellow ^ EW_Yellow;
      cycles(1);
    end
    sensor = 1'b0;
    cycles(300);

    check("scoreboard_drained", exp_q.size(), 0);
    check("lamp_invariants", inv_errors, 0);
    check("free_ew_services", int'(ew_runs >= 40), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog: the stimulus is fixed-length, so this only fires on a bench hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1);
  end

endmodule
